// File: rtl/gpio_rgb_pixel_unpacker_if.sv
// rtl/gpio_rgb_pixel_unpacker_if.sv - GPIO channel-word capture and RGB pixel stream bundle
interface gpio_rgb_pixel_unpacker_if;
   logic [31:0] GPIO;
   logic        GPIOEnR;
   logic        GPIOEnG;
   logic        GPIOEnB;
   logic        GPIOEn;
   logic        pix_ready;
   logic        pix_valid;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic [17:0] pix_count;
   logic        frame_done;
   logic        overflow;
   logic        order_err;

   modport master (
      output GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, pix_ready,
      input  pix_valid, pix_r, pix_g, pix_b, pix_count, frame_done, overflow, order_err
   );

   modport slave (
      input  GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, pix_ready,
      output pix_valid, pix_r, pix_g, pix_b, pix_count, frame_done, overflow, order_err
   );
endinterface

// File: rtl/gpio_rgb_pixel_unpacker.sv
// rtl/gpio_rgb_pixel_unpacker.sv - assemble GPIO R/G/B words into a FIFO and stream 24-bit pixels
module gpio_rgb_pixel_unpacker #(
   parameter int DEPTH      = 4,
   parameter int MAX_PIXELS = 160000
) (
   input  logic                        clk,
   input  logic                        rst,
   gpio_rgb_pixel_unpacker_if.slave    bus
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [17:0] LAST_PIX = 18'(MAX_PIXELS - 1);

   typedef enum logic [1:0] {WAIT_R, WAIT_G, WAIT_B} state_t;

   state_t      state, state_next;
   logic        armed;
   logic [31:0] hold_r, hold_g;
   logic [31:0] mem_r [DEPTH];
   logic [31:0] mem_g [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic [AW:0] wptr, rptr;
   logic [1:0]  byte_idx;
   logic [17:0] pix_count_q;
   logic        frame_done_q, overflow_q, order_err_q;

   logic        accept, any_stb, multi_stb;
   logic        load_r, load_g, push_req, stb_err;
   logic        full, empty, xfer, pop, push;
   logic [31:0] head_r, head_g, head_b;
   logic [4:0]  bit_sel;

   // GPIOEn in the strobe cycle itself is enough to accept that strobe
   assign accept    = armed | bus.GPIOEn;
   assign any_stb   = accept & (bus.GPIOEnR | bus.GPIOEnG | bus.GPIOEnB);
   assign multi_stb = accept & ((bus.GPIOEnR & bus.GPIOEnG) |
                                (bus.GPIOEnR & bus.GPIOEnB) |
                                (bus.GPIOEnG & bus.GPIOEnB));

   always_comb begin
      state_next = state;
      load_r     = 1'b0;
      load_g     = 1'b0;
      push_req   = 1'b0;
      stb_err    = 1'b0;
      if (any_stb) begin
         if (multi_stb) begin
            stb_err = 1'b1;
         end else begin
            case (state)
               WAIT_R: begin
                  if (bus.GPIOEnR) begin
                     load_r     = 1'b1;
                     state_next = WAIT_G;
                  end else begin
                     stb_err = 1'b1;
                  end
               end
               WAIT_G: begin
                  if (bus.GPIOEnG) begin
                     load_g     = 1'b1;
                     state_next = WAIT_B;
                  end else begin
                     stb_err = 1'b1;
                  end
               end
               WAIT_B: begin
                  if (bus.GPIOEnB) begin
                     push_req   = 1'b1;
                     state_next = WAIT_R;
                  end else begin
                     stb_err = 1'b1;
                  end
               end
               default: state_next = WAIT_R;
            endcase
         end
      end
   end

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign xfer  = !empty && bus.pix_ready;
   assign pop   = xfer && (byte_idx == 2'd3);
   // a full FIFO still takes the triple if its head group leaves this same cycle
   assign push  = push_req && (!full || pop);

   assign head_r  = mem_r[rptr[AW-1:0]];
   assign head_g  = mem_g[rptr[AW-1:0]];
   assign head_b  = mem_b[rptr[AW-1:0]];
   assign bit_sel = {byte_idx, 3'b000};

   assign bus.pix_valid  = !empty;
   assign bus.pix_r      = empty ? 8'h00 : head_r[bit_sel +: 8];
   assign bus.pix_g      = empty ? 8'h00 : head_g[bit_sel +: 8];
   assign bus.pix_b      = empty ? 8'h00 : head_b[bit_sel +: 8];
   assign bus.pix_count  = pix_count_q;
   assign bus.frame_done = frame_done_q;
   assign bus.overflow   = overflow_q;
   assign bus.order_err  = order_err_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wptr[AW-1:0]] <= hold_r;
         mem_g[wptr[AW-1:0]] <= hold_g;
         mem_b[wptr[AW-1:0]] <= bus.GPIO;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= WAIT_R;
         armed        <= 1'b0;
         hold_r       <= '0;
         hold_g       <= '0;
         wptr         <= '0;
         rptr         <= '0;
         byte_idx     <= '0;
         pix_count_q  <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         order_err_q  <= 1'b0;
      end else begin
         state        <= state_next;
         armed        <= armed | bus.GPIOEn;
         if (load_r) hold_r <= bus.GPIO;
         if (load_g) hold_g <= bus.GPIO;
         if (push)   wptr   <= wptr + 1'b1;
         if (pop)    rptr   <= rptr + 1'b1;
         // byte index wraps 3 -> 0 on its own, matching the pop
         if (xfer) begin
            byte_idx    <= byte_idx + 2'd1;
            pix_count_q <= (pix_count_q == LAST_PIX) ? 18'd0 : pix_count_q + 18'd1;
         end
         frame_done_q <= xfer && (pix_count_q == LAST_PIX);
         if (push_req && !push) overflow_q  <= 1'b1;
         if (stb_err)           order_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gpio_rgb_pixel_unpacker.sv
// tb/tb_gpio_rgb_pixel_unpacker.sv - directed self-checking bench for gpio_rgb_pixel_unpacker
module tb_gpio_rgb_pixel_unpacker;

   logic clk = 1'b0;
   logic rst;
   int   tests_run = 0;
   int   tests_failed = 0;

   gpio_rgb_pixel_unpacker_if bus();

   gpio_rgb_pixel_unpacker #(.DEPTH(4), .MAX_PIXELS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input int cnt);
      check({tag, "_valid"}, 32'(bus.pix_valid), 32'd1);
      check({tag, "_r"}, 32'(bus.pix_r), 32'(r));
      check({tag, "_g"}, 32'(bus.pix_g), 32'(g));
      check({tag, "_b"}, 32'(bus.pix_b), 32'(b));
      check({tag, "_cnt"}, 32'(bus.pix_count), 32'(cnt));
   endtask

   // ch: 0=R 1=G 2=B
   task automatic send(input int ch, input logic [31:0] w);
      bus.GPIO    = w;
      bus.GPIOEnR = (ch == 0);
      bus.GPIOEnG = (ch == 1);
      bus.GPIOEnB = (ch == 2);
      tick();
      bus.GPIOEnR = 1'b0;
      bus.GPIOEnG = 1'b0;
      bus.GPIOEnB = 1'b0;
   endtask

   task automatic triple(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
      send(0, r);
      send(1, g);
      send(2, b);
   endtask

   initial begin
      bus.GPIO = '0; bus.GPIOEnR = 0; bus.GPIOEnG = 0; bus.GPIOEnB = 0;
      bus.GPIOEn = 0; bus.pix_ready = 0;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      check("rst_valid", 32'(bus.pix_valid), 0);
      check("rst_r", 32'(bus.pix_r), 0);
      check("rst_frame_done", 32'(bus.frame_done), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      check("rst_order_err", 32'(bus.order_err), 0);
      check("rst_count", 32'(bus.pix_count), 0);

      // strobes before arming are silently ignored, out-of-order ones too
      bus.pix_ready = 1'b1;
      send(1, 32'hDEADBEEF);
      triple(32'h1, 32'h2, 32'h3);
      tick();
      check("unarmed_valid", 32'(bus.pix_valid), 0);
      check("unarmed_order_err", 32'(bus.order_err), 0);
      check("unarmed_count", 32'(bus.pix_count), 0);

      // basic group
      bus.GPIOEn = 1'b1;
      tick();
      bus.GPIOEn = 1'b0;
      triple(32'h44332211, 32'h88776655, 32'hCCBBAA99);
      chk_pix("basic0", 8'h11, 8'h55, 8'h99, 0);
      tick();
      chk_pix("basic1", 8'h22, 8'h66, 8'hAA, 1);
      tick();
      chk_pix("basic2", 8'h33, 8'h77, 8'hBB, 2);
      tick();
      chk_pix("basic3", 8'h44, 8'h88, 8'hCC, 3);
      tick();
      check("basic_drained", 32'(bus.pix_valid), 0);
      check("basic_count", 32'(bus.pix_count), 4);
      check("basic_order_err", 32'(bus.order_err), 0);

      // order error then a good triple; frame wraps after pixel index 7
      send(1, 32'h01010101);
      check("oerr_flag", 32'(bus.order_err), 1);
      check("oerr_valid", 32'(bus.pix_valid), 0);
      triple(32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A);
      chk_pix("oerr0", 8'h0A, 8'h1A, 8'h2A, 4);
      check("fd_low", 32'(bus.frame_done), 0);
      tick();
      chk_pix("oerr1", 8'h0B, 8'h1B, 8'h2B, 5);
      tick();
      chk_pix("oerr2", 8'h0C, 8'h1C, 8'h2C, 6);
      tick();
      chk_pix("oerr3", 8'h0D, 8'h1D, 8'h2D, 7);
      tick();
      check("wrap_frame_done", 32'(bus.frame_done), 1);
      check("wrap_count", 32'(bus.pix_count), 0);
      check("wrap_valid", 32'(bus.pix_valid), 0);
      tick();
      check("wrap_fd_pulse", 32'(bus.frame_done), 0);
      triple(32'h03020100, 32'h13121110, 32'h23222120);
      chk_pix("post_wrap0", 8'h00, 8'h10, 8'h20, 0);
      tick(); tick(); tick(); tick();
      check("post_wrap_count", 32'(bus.pix_count), 4);
      check("post_wrap_valid", 32'(bus.pix_valid), 0);

      // backpressure and overflow
      bus.pix_ready = 1'b0;
      for (int t = 1; t <= 4; t++)
         triple(32'h03020100 + t * 32'h10101010, 32'h43424140 + t * 32'h10101010,
                32'h83828180 + t * 32'h10101010);
      check("ovf_not_yet", 32'(bus.overflow), 0);
      triple(32'h03020100 + 5 * 32'h10101010, 32'h43424140 + 5 * 32'h10101010,
             32'h83828180 + 5 * 32'h10101010);
      check("ovf_set", 32'(bus.overflow), 1);
      chk_pix("hold0", 8'h10, 8'h50, 8'h90, 4);
      tick();
      chk_pix("hold1", 8'h10, 8'h50, 8'h90, 4);
      bus.pix_ready = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         for (int j = 0; j < 4; j++) begin
            check("drain_r", 32'(bus.pix_r), 32'(8'(16 * t + j)));
            check("drain_g", 32'(bus.pix_g), 32'(8'(16 * t + j + 8'h40)));
            check("drain_b", 32'(bus.pix_b), 32'(8'(16 * t + j + 8'h80)));
            tick();
         end
      end
      check("drain_5th_absent", 32'(bus.pix_valid), 0);
      check("drain_count", 32'(bus.pix_count), 4);
      check("ovf_sticky", 32'(bus.overflow), 1);

      // reset mid-stream with 2 triples buffered and FSM in WAIT_G
      bus.pix_ready = 1'b0;
      triple(32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0);
      triple(32'hA7A6A5A4, 32'hB7B6B5B4, 32'hC7C6C5C4);
      send(0, 32'hEEEEEEEE);
      check("pre_rst_valid", 32'(bus.pix_valid), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid_rst_valid", 32'(bus.pix_valid), 0);
      check("mid_rst_overflow", 32'(bus.overflow), 0);
      check("mid_rst_order_err", 32'(bus.order_err), 0);
      check("mid_rst_count", 32'(bus.pix_count), 0);
      bus.pix_ready = 1'b1;
      triple(32'h11111111, 32'h22222222, 32'h33333333);
      tick();
      check("disarmed_valid", 32'(bus.pix_valid), 0);
      bus.GPIOEn = 1'b1;
      send(0, 32'h64636261);
      bus.GPIOEn = 1'b0;
      send(1, 32'h74737271);
      send(2, 32'h84838281);
      chk_pix("rearm0", 8'h61, 8'h71, 8'h81, 0);
      tick();
      chk_pix("rearm1", 8'h62, 8'h72, 8'h82, 1);
      check("rearm_order_err", 32'(bus.order_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
